// File: rtl/cell_pos_pkg.sv
// Shared definitions for the per-cell position reader: record layout,
// fixed memory map / latency and the controller state encoding.
package cell_pos_pkg;

  localparam int POS_WIDTH  = 32;
  localparam int DATA_WIDTH = 3 * POS_WIDTH;

  localparam int POSX_LSB = 0;
  localparam int POSY_LSB = POS_WIDTH;
  localparam int POSZ_LSB = 2 * POS_WIDTH;

  localparam int COUNT_ADDR = 0;
  localparam int RD_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE,
    CNT_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] pack_pos(input logic [POS_WIDTH-1:0] x,
                                                     input logic [POS_WIDTH-1:0] y,
                                                     input logic [POS_WIDTH-1:0] z);
    return {z, y, x};
  endfunction

endpackage

// File: rtl/pos_stream_fifo.sv
// Synchronous FIFO whose head entry lives in an output register; level counts
// the head plus the DEPTH-1 entries of backing storage.
module pos_stream_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int STORE = DEPTH - 1;
  localparam int PTR_W = (STORE > 1) ? $clog2(STORE) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [STORE];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] st_cnt;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;

  logic pop;
  logic head_load;
  logic st_pop;
  logic st_push;
  logic bypass;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STORE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    pop       = head_valid && rd_ready;
    head_load = !head_valid || pop;
    st_pop    = head_load && (st_cnt != '0);
    bypass    = head_load && (st_cnt == '0) && wr_en;
    st_push   = wr_en && !bypass;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      st_cnt     <= '0;
    end else begin
      if (head_load) begin
        if (st_pop) begin
          head_data  <= mem[rd_ptr];
          head_valid <= 1'b1;
        end else if (bypass) begin
          head_data  <= wr_data;
          head_valid <= 1'b1;
        end else begin
          head_valid <= 1'b0;
        end
      end
      if (st_push) wr_ptr <= next_ptr(wr_ptr);
      if (st_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({st_push, st_pop})
        2'b10:   st_cnt <= st_cnt + LVL_W'(1);
        2'b01:   st_cnt <= st_cnt - LVL_W'(1);
        default: st_cnt <= st_cnt;
      endcase
    end
  end

  // NOTE: storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clock) begin
    if (st_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_valid = head_valid;
  assign rd_data  = head_data;
  assign level    = st_cnt + LVL_W'(head_valid);

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count from address 0 of a cell memory, then streams
// records 1..N out over valid/ready with credit-limited read issue.
module cell_pos_reader
  import cell_pos_pkg::state_t, cell_pos_pkg::IDLE, cell_pos_pkg::CNT_WAIT,
         cell_pos_pkg::STREAM, cell_pos_pkg::DRAIN, cell_pos_pkg::DONE,
         cell_pos_pkg::COUNT_ADDR;
#(
  parameter int DATA_WIDTH   = cell_pos_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = cell_pos_pkg::RD_LATENCY,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] cell_address,
  output logic                  cell_rden,
  output logic                  cell_wren,
  output logic [DATA_WIDTH-1:0] cell_data,
  input  logic [DATA_WIDTH-1:0] cell_q,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int REC_W  = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W   = $clog2(RD_LATENCY + 1);
  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_check
    $error("cell_pos_reader: FIFO_DEPTH must be at least RD_LATENCY+1");
  end

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [ADDR_WIDTH-1:0] idx;
  } tag_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WAIT_W-1:0]     wait_cnt;
  tag_t                  tags [RD_LATENCY];
  logic [IF_W-1:0]       in_flight;
  logic [LVL_W-1:0]      fifo_level;
  logic [REC_W-1:0]      head_data;

  logic                  start_ok;
  logic                  credit_ok;
  logic                  cnt_latch;
  logic                  fifo_pop;
  logic [ADDR_WIDTH-1:0] raw_count;
  logic                  count_over;
  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] issue_addr;

  // A start sampled while rst is high must not reach the memory port.
  assign start_ok   = start && !rst;
  assign raw_count  = cell_q[ADDR_WIDTH-1:0];
  assign count_over = raw_count > CNT_MAX;
  assign cnt_latch  = (state == CNT_WAIT) && (wait_cnt == WAIT_W'(RD_LATENCY - 1));
  assign fifo_pop   = out_valid && out_ready;
  assign credit_ok  = (int'(in_flight) + int'(fifo_level)) < FIFO_DEPTH;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + IF_W'(tags[i].valid);
    end
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = addr_q;
    case (state)
      IDLE: begin
        if (start_ok) begin
          issue      = 1'b1;
          issue_addr = ADDR_WIDTH'(COUNT_ADDR);
          state_nxt  = CNT_WAIT;
        end
      end
      CNT_WAIT: begin
        if (cnt_latch) state_nxt = (raw_count == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_addr = rd_ptr;
          issue_last = (rd_ptr == particle_count);
          if (rd_ptr == particle_count) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the final record is leaving the output register.
        if (in_flight == '0 &&
            (fifo_level == '0 || (fifo_level == LVL_W'(1) && fifo_pop))) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      addr_q         <= '0;
      wait_cnt       <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) tags[i] <= '0;
    end else begin
      state <= state_nxt;
      if (issue) addr_q <= issue_addr;
      wait_cnt <= (state == CNT_WAIT) ? wait_cnt + WAIT_W'(1) : '0;

      if (state == IDLE && start_ok) count_err <= 1'b0;
      if (cnt_latch) begin
        particle_count <= count_over ? CNT_MAX : raw_count;
        count_err      <= count_over;
        rd_ptr         <= ADDR_WIDTH'(1);
      end else if (state == STREAM && issue) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end

      // Only record reads are tagged; the count read is handled by CNT_WAIT.
      tags[0] <= '{valid: issue && (state == STREAM), last: issue_last, idx: issue_addr};
      for (int i = 1; i < RD_LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  pos_stream_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .rst      (rst),
    .wr_en    (tags[RD_LATENCY-1].valid),
    .wr_data  ({tags[RD_LATENCY-1].last, tags[RD_LATENCY-1].idx, cell_q}),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (head_data),
    .level    (fifo_level)
  );

  assign {out_last, out_index, out_pos} = head_data;

  assign busy         = (state == CNT_WAIT) || (state == STREAM) || (state == DRAIN);
  assign done         = (state == DONE);
  assign cell_rden    = issue;
  assign cell_address = issue_addr;
  assign cell_wren    = 1'b0;
  assign cell_data    = '0;

endmodule

// File: doc/cell_pos_reader.md
Name: cell_pos_reader

Overview:
- Read-side controller for one per-cell position memory. Address 0 holds the particle count; addresses 1..N hold {posz, posy, posx}. The memory has 2-cycle read latency.
- On `start`, fetches the count, then streams every particle record to the force-evaluation pipeline over a valid/ready interface.
- Credit-based flow control means no read data is ever lost under backpressure.

Parameters:
- DATA_WIDTH, 96, width of one position record {posz, posy, posx}, 32 bits each.
- ADDR_WIDTH, 8, memory address width.
- PARTICLE_NUM, 220, memory depth; the maximum legal count is PARTICLE_NUM-1.
- RD_LATENCY, 2, memory read latency in cycles.
- FIFO_DEPTH, 4, output buffer depth; must be >= RD_LATENCY+2 for full throughput (elaboration error if < RD_LATENCY+1).

Ports:
- clock  in  1  single clock for the whole block.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle request to read the whole cell; ignored while busy=1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of operation.
- particle_count  out  ADDR_WIDTH  latched, clamped count.
- count_err  out  1  sticky until next start; raw count exceeded PARTICLE_NUM-1.
- cell_address  out  ADDR_WIDTH  memory address.
- cell_rden  out  1  memory read enable.
- cell_wren  out  1  constant 0.
- cell_data  out  DATA_WIDTH  constant 0.
- cell_q  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after rden.
- out_pos  out  DATA_WIDTH  particle record.
- out_index  out  ADDR_WIDTH  source address (1..N) of out_pos.
- out_last  out  1  marks the final record.
- out_valid  out  1  record valid.
- out_ready  in  1  downstream accept; a transfer occurs when out_valid && out_ready.

Behaviour:
- Reset: every output 0. FSM goes to IDLE. FIFO and the in-flight valid shift register are cleared; data already in flight is discarded. Reset mid-operation produces no done pulse.
- Count field: the count is cell_q[ADDR_WIDTH-1:0] read from address 0.
  - If raw > PARTICLE_NUM-1: count = PARTICLE_NUM-1 and count_err=1.
- FSM states:
  - IDLE: on start, drive cell_address=0 and cell_rden=1 in the same cycle (cycle 0); go to CNT_WAIT. Clear count_err. busy=1 from cycle 1.
  - CNT_WAIT: wait RD_LATENCY cycles, then latch particle_count from cell_q at cycle 2.
    - If count=0, go to DONE.
    - Otherwise go to STREAM and set rd_ptr=1.
  - STREAM: issue a read of rd_ptr when (in_flight + fifo_occupancy) < FIFO_DEPTH, then increment rd_ptr.
    - After issuing address = count, go to DRAIN.
    - The first particle read is issued at cycle 3.
  - DRAIN: no new reads. Wait until in_flight=0, FIFO empty, and the last transfer has completed; then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Read pipeline:
  - A RD_LATENCY-deep valid/address shift register tags returning data with its index.
  - Data is written into the FIFO in the cycle cell_q is valid.
  - The FIFO output is registered: out_valid rises the cycle after the write.
- Latency: with out_ready held high,
  - first record out_valid at cycle 6 (index 1);
  - one record per cycle thereafter;
  - last record at cycle 5+N;
  - done at cycle 6+N.
- Backpressure: out_pos, out_index and out_last hold stable while out_valid && !out_ready. The credit check guarantees the FIFO never overflows.
- cell_rden=0 whenever no read is issued; cell_address holds its last value.
- out_last=1 only on the record whose out_index equals particle_count.
- A start in any non-IDLE state is ignored. A start coincident with rst is ignored.

Decomposition:
- Shared package cell_pos_pkg holds:
  - POS_WIDTH=32 and DATA_WIDTH=3*POS_WIDTH;
  - field slice constants for posx/posy/posz;
  - COUNT_ADDR=0 and RD_LATENCY=2;
  - the FSM state encoding (IDLE, CNT_WAIT, STREAM, DRAIN, DONE).
- One sub-module: pos_stream_fifo, a synchronous FIFO of FIFO_DEPTH × (DATA_WIDTH+ADDR_WIDTH+1) with registered output and an occupancy count.

Test Plan:
- Memory model with count=5, records 1..5 distinct, out_ready=1, start at cycle 0 -> rden at addr 0 in cycle 0; addrs 1..5 read in cycles 3..7; out_index 1..5 in cycles 6..10; out_last at cycle 10; done at cycle 11; count_err=0.
- count=8, out_ready toggling 1,0,0,1 repeating -> all 8 records in order; no drops or duplicates; out_pos stable during stalls; in_flight+occupancy never exceeds 4.
- count=0 -> no reads beyond addr 0; out_valid never asserts; done pulses at cycle 3; particle_count=0.
- Raw count=250 with PARTICLE_NUM=220 -> particle_count=219, count_err=1, exactly 219 records, out_last on index 219.
- rst asserted while 2 reads are in flight and the FIFO holds 2 records -> all outputs 0 immediately; no done; a subsequent start with count=3 yields exactly 3 clean records.
- start pulsed again at cycle 4 of an active count=5 run -> ignored; exactly 5 records and one done pulse.
